// File: rtl/debug_sba_engine.sv
// RISC-V debug system-bus-access engine: DMI-mapped sbcs/sbaddress/sbdata driving a valid/ready bus master.
// DMI ack one cycle after accept; bus request held until bus_req_ready; response awaited up to TIMEOUT_CYC cycles.
module debug_sba_engine #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmactive,
  input  logic              dmi_req,
  input  logic [1:0]        dmi_op,
  input  logic [6:0]        dmi_addr,
  input  logic [31:0]       dmi_wdata,
  output logic              dmi_ack,
  output logic [31:0]       dmi_rdata,
  output logic [1:0]        dmi_resp,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [2:0]        bus_size,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_data,
  input  logic              bus_rsp_err,
  output logic              bus_abort
);

  localparam bit HAS_A1 = (ADDR_W > 32);
  localparam bit HAS_D1 = (DATA_W == 64);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  state_t r_state, w_state_nxt;

  logic              r_sbbusyerror, r_sbreadonaddr, r_sbautoinc, r_sbreadondata, r_we;
  logic [2:0]        r_sbaccess, r_sberror, r_size;
  logic [ADDR_W-1:0] r_sbaddress, r_addr;
  logic [DATA_W-1:0] r_sbdata, r_wdata;
  logic [15:0]       r_cnt;

  logic w_acc, w_rd, w_wr, w_busy, w_busyerr_set, w_trig, w_trig_we, w_blocked;
  logic w_sel_cs, w_sel_a0, w_sel_a1, w_sel_d0, w_sel_d1;
  logic w_unsup, w_misal, w_start, w_chk_err, w_tmo, w_timeout, w_rsp_ok, w_rsp_err;
  logic [63:0]       w_addr64, w_data64;
  logic [ADDR_W-1:0] w_addr_a0_new, w_addr_a1_new, w_trig_addr, w_align_mask;
  logic [DATA_W-1:0] w_data_d0_new, w_data_d1_new, w_trig_data;
  logic [31:0]       w_rdata;

  function automatic logic [DATA_W-1:0] f_size_mask(input logic [2:0] sz);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W/8; i++)
      if (i < (1 << sz)) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  assign w_acc    = dmi_req && !dmi_ack;
  assign w_rd     = w_acc && (dmi_op == 2'd1);
  assign w_wr     = w_acc && (dmi_op == 2'd2);
  assign w_sel_cs = (dmi_addr == 7'h38);
  assign w_sel_a0 = (dmi_addr == 7'h39);
  assign w_sel_a1 = (dmi_addr == 7'h3A) && HAS_A1;
  assign w_sel_d0 = (dmi_addr == 7'h3C);
  assign w_sel_d1 = (dmi_addr == 7'h3D) && HAS_D1;
  assign w_busy   = (r_state != S_IDLE);

  // 64-bit views let the 32-bit DMI halves be spliced in for any legal width
  assign w_addr64      = 64'(r_sbaddress);
  assign w_data64      = 64'(r_sbdata);
  assign w_addr_a0_new = ADDR_W'({w_addr64[63:32], dmi_wdata});
  assign w_addr_a1_new = ADDR_W'({dmi_wdata, w_addr64[31:0]});
  assign w_data_d0_new = DATA_W'({w_data64[63:32], dmi_wdata});
  assign w_data_d1_new = DATA_W'({dmi_wdata, w_data64[31:0]});

  assign w_busyerr_set = (w_rd || w_wr) && (w_sel_a0 || w_sel_a1 || w_sel_d0 || w_sel_d1) && w_busy;
  assign w_trig_we     = w_wr && w_sel_d0;
  assign w_trig        = !w_busy && (w_trig_we || (w_wr && w_sel_a0 && r_sbreadonaddr) ||
                                     (w_rd && w_sel_d0 && r_sbreadondata));
  assign w_blocked     = (r_sberror != 3'd0) || r_sbbusyerror;
  assign w_trig_addr   = (w_wr && w_sel_a0) ? w_addr_a0_new : r_sbaddress;
  assign w_trig_data   = w_trig_we ? w_data_d0_new : r_sbdata;
  assign w_unsup       = (r_sbaccess > 3'd3) || ((r_sbaccess == 3'd3) && !HAS_D1);
  assign w_align_mask  = ADDR_W'((64'd1 << r_sbaccess) - 64'd1);
  assign w_misal       = |(w_trig_addr & w_align_mask);
  assign w_chk_err     = w_trig && !w_blocked && (w_unsup || w_misal);
  assign w_start       = w_trig && !w_blocked && !w_unsup && !w_misal;
  assign w_tmo         = (r_cnt == 16'(TIMEOUT_CYC));

  always_comb begin
    w_rdata = '0;
    if (w_sel_cs)
      w_rdata = {3'd1, 6'd0, r_sbbusyerror, w_busy, r_sbreadonaddr, r_sbaccess, r_sbautoinc,
                 r_sbreadondata, r_sberror, 7'(ADDR_W), 1'b0, HAS_D1, 3'b111};
    else if (w_sel_a0) w_rdata = w_addr64[31:0];
    else if (w_sel_a1) w_rdata = w_addr64[63:32];
    else if (w_sel_d0) w_rdata = w_data64[31:0];
    else if (w_sel_d1) w_rdata = w_data64[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else if (!dmactive) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timeout     = 1'b0;
    w_rsp_ok      = 1'b0;
    w_rsp_err     = 1'b0;
    bus_req_valid = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_tmo) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          bus_req_valid = 1'b1;
          if (bus_req_ready) w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        // a response in the deadline cycle still counts as on time
        if (bus_rsp_valid) begin
          w_rsp_err   = bus_rsp_err;
          w_rsp_ok    = !bus_rsp_err;
          w_state_nxt = S_IDLE;
        end else if (w_tmo) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus_abort = w_timeout;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_size  = r_size;
  assign bus_wdata = r_wdata;
  assign dmi_resp  = 2'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (!dmactive || r_state == S_IDLE) r_cnt <= '0;
    else r_cnt <= r_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmi_ack   <= 1'b0;
      dmi_rdata <= '0;
    end else begin
      dmi_ack   <= w_acc;
      dmi_rdata <= w_rd ? w_rdata : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sbbusyerror <= 1'b0; r_sbreadonaddr <= 1'b0; r_sbautoinc <= 1'b0; r_sbreadondata <= 1'b0;
      r_sbaccess <= 3'd2; r_sberror <= 3'd0; r_sbaddress <= '0; r_sbdata <= '0;
      r_we <= 1'b0; r_addr <= '0; r_size <= 3'd0; r_wdata <= '0;
    end else if (!dmactive) begin
      r_sbbusyerror <= 1'b0; r_sbreadonaddr <= 1'b0; r_sbautoinc <= 1'b0; r_sbreadondata <= 1'b0;
      r_sbaccess <= 3'd2; r_sberror <= 3'd0; r_sbaddress <= '0; r_sbdata <= '0;
      r_we <= 1'b0; r_addr <= '0; r_size <= 3'd0; r_wdata <= '0;
    end else begin
      if (w_wr && w_sel_cs) begin
        if (dmi_wdata[22]) r_sbbusyerror <= 1'b0;
        r_sbreadonaddr <= dmi_wdata[20];
        r_sbaccess     <= dmi_wdata[19:17];
        r_sbautoinc    <= dmi_wdata[16];
        r_sbreadondata <= dmi_wdata[15];
        r_sberror      <= r_sberror & ~dmi_wdata[14:12];
      end
      if (w_wr && !w_busy) begin
        if (w_sel_a0) r_sbaddress <= w_addr_a0_new;
        if (w_sel_a1) r_sbaddress <= w_addr_a1_new;
        if (w_sel_d0) r_sbdata    <= w_data_d0_new;
        if (w_sel_d1) r_sbdata    <= w_data_d1_new;
      end
      if (w_busyerr_set) r_sbbusyerror <= 1'b1;
      if (w_chk_err) r_sberror <= w_unsup ? 3'd4 : 3'd3;
      if (w_start) begin
        r_we    <= w_trig_we;
        r_addr  <= w_trig_addr;
        r_size  <= r_sbaccess;
        r_wdata <= w_trig_we ? (w_trig_data & f_size_mask(r_sbaccess)) : '0;
      end
      // later assignments win so a fresh bus error overrides a same-cycle W1C
      if (w_timeout) r_sberror <= 3'd1;
      if (w_rsp_err) r_sberror <= 3'd2;
      if (w_rsp_ok) begin
        if (!r_we) r_sbdata <= bus_rsp_data & f_size_mask(r_size);
        if (r_sbautoinc) r_sbaddress <= r_sbaddress + (ADDR_W'(1) << r_size);
      end
    end
  end

endmodule

// File: tb/tb_debug_sba_engine.sv
// Directed bench for debug_sba_engine: DMI driver, scoreboarded bus monitor/responder, timeout and reset checks.
module tb_debug_sba_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmactive = 1'b1;
  logic        dmi_req = 1'b0;
  logic [1:0]  dmi_op = 2'd0;
  logic [6:0]  dmi_addr = 7'd0;
  logic [31:0] dmi_wdata = 32'd0;
  logic        dmi_ack;
  logic [31:0] dmi_rdata;
  logic [1:0]  dmi_resp;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b1;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [2:0]  bus_size;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rsp_data = 32'd0;
  logic        bus_rsp_err = 1'b0;
  logic        bus_abort;

  debug_sba_engine #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .dmactive(dmactive),
    .dmi_req(dmi_req), .dmi_op(dmi_op), .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata),
    .dmi_ack(dmi_ack), .dmi_rdata(dmi_rdata), .dmi_resp(dmi_resp),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_size(bus_size), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data), .bus_rsp_err(bus_rsp_err),
    .bus_abort(bus_abort)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata; } breq_t;
  typedef struct packed { logic err; logic [31:0] data; } rsp_t;

  breq_t       exp_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] rd_q[$];
  int tests = 0, fails = 0;
  int rsp_delay = 1;
  int cyc = 0, acc_cnt = 0, abort_cnt = 0, abort_cyc = 0, first_vld_cyc = 0;
  logic vld_d = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_abort) begin abort_cnt++; abort_cyc = cyc; end
    if (bus_req_valid && !vld_d) first_vld_cyc = cyc;
    vld_d = bus_req_valid;
  end

  // bus monitor + responder: compares each accepted request against the scoreboard
  initial begin
    breq_t e;
    rsp_t  r;
    forever begin
      @(negedge clk);
      if (bus_req_valid && bus_req_ready) begin
        acc_cnt++;
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL bus_req_unexpected: observed addr=0x%0h expected=no request", bus_addr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("bus_we", bus_we, e.we);
          check("bus_addr", bus_addr, e.addr);
          check("bus_size", bus_size, e.size);
          if (e.we) check("bus_wdata", bus_wdata, e.wdata);
        end
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          repeat (rsp_delay) @(posedge clk);
          #1;
          bus_rsp_valid = 1'b1; bus_rsp_data = r.data; bus_rsp_err = r.err;
          @(posedge clk);
          #1;
          bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
        end
      end
    end
  end

  task automatic dmi_xfer(input logic [1:0] op, input logic [6:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic ok);
    ok = 1'b0;
    rd = '0;
    @(negedge clk);
    dmi_req = 1'b1; dmi_op = op; dmi_addr = a; dmi_wdata = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dmi_ack) begin ok = 1'b1; rd = dmi_rdata; break; end
    end
    dmi_req = 1'b0; dmi_op = 2'd0;
    if (!ok) begin
      tests++; fails++;
      $error("FAIL dmi_ack_timeout: observed=no ack expected=ack (addr 0x%0h)", a);
    end
  endtask

  task automatic dmi_wr(input logic [6:0] a, input logic [31:0] wd);
    logic [31:0] r;
    logic ok;
    dmi_xfer(2'd2, a, wd, r, ok);
  endtask

  task automatic dmi_rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic ok;
    rd_q.push_back(exp);
    dmi_xfer(2'd1, a, 32'd0, r, ok);
    if (ok) check(tag, r, rd_q.pop_front());
    else void'(rd_q.pop_front());
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] r;
    logic ok;
    r = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      dmi_xfer(2'd1, 7'h38, 32'd0, r, ok);
      if (!r[21]) break;
    end
    check(tag, r[21], 1'b0);
  endtask

  task automatic expect_bus(input logic we, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] wd, input logic err, input logic [31:0] rdat);
    exp_q.push_back('{we: we, addr: a, size: sz, wdata: wd});
    rsp_q.push_back('{err: err, data: rdat});
  endtask

  initial begin
    int acc0;
    repeat (3) @(negedge clk);
    check("reset_dmi_ack", dmi_ack, 1'b0);
    check("reset_bus_req_valid", bus_req_valid, 1'b0);
    check("reset_bus_abort", bus_abort, 1'b0);
    check("reset_bus_addr", bus_addr, 32'd0);
    rst_n = 1'b1;
    dmi_rd("reset_sbcs", 7'h38, 32'h2004_0407);
    dmi_rd("reset_sbaddress0", 7'h39, 32'd0);
    dmi_rd("reset_sbdata0", 7'h3C, 32'd0);
    dmi_rd("unmapped_sbaddress1", 7'h3A, 32'd0);
    check("dmi_resp", dmi_resp, 2'd0);

    // 32-bit write with autoincrement
    dmi_wr(7'h38, 32'h0005_0000);
    dmi_wr(7'h39, 32'h0000_1000);
    rsp_delay = 1;
    expect_bus(1'b1, 32'h1000, 3'd2, 32'hDEAD_BEEF, 1'b0, 32'd0);
    dmi_wr(7'h3C, 32'hDEAD_BEEF);
    wait_idle("wr_idle");
    dmi_rd("wr_autoinc_addr", 7'h39, 32'h0000_1004);
    dmi_rd("wr_sbcs", 7'h38, 32'h2005_0407);

    // read on address write; busy spans accept to response
    dmi_wr(7'h38, 32'h0014_0000);
    rsp_delay = 3;
    expect_bus(1'b0, 32'h2000, 3'd2, 32'd0, 1'b0, 32'h1234_5678);
    dmi_wr(7'h39, 32'h0000_2000);
    dmi_rd("rd_busy_early", 7'h38, 32'h2034_0407);
    dmi_rd("rd_busy_last", 7'h38, 32'h2034_0407);
    dmi_rd("rd_busy_clear", 7'h38, 32'h2014_0407);
    dmi_rd("rd_sbdata0", 7'h3C, 32'h1234_5678);

    // byte reads chained through readondata with autoincrement
    dmi_wr(7'h38, 32'h0011_8000);
    rsp_delay = 2;
    expect_bus(1'b0, 32'h3000, 3'd0, 32'd0, 1'b0, 32'hAABB_CCDD);
    dmi_wr(7'h39, 32'h0000_3000);
    wait_idle("byte_idle0");
    expect_bus(1'b0, 32'h3001, 3'd0, 32'd0, 1'b0, 32'h0000_00EE);
    dmi_rd("byte_rd0", 7'h3C, 32'h0000_00DD);
    wait_idle("byte_idle1");
    dmi_wr(7'h38, 32'h0001_0000);
    dmi_rd("byte_rd1", 7'h3C, 32'h0000_00EE);
    dmi_rd("byte_addr", 7'h39, 32'h0000_3002);

    // busy error while response is withheld
    dmi_wr(7'h38, 32'h0004_0000);
    dmi_wr(7'h39, 32'h0000_4000);
    rsp_delay = 6;
    expect_bus(1'b1, 32'h4000, 3'd2, 32'h1111_1111, 1'b0, 32'd0);
    dmi_wr(7'h3C, 32'h1111_1111);
    dmi_wr(7'h3C, 32'h2222_2222);
    wait_idle("busyerr_idle");
    dmi_rd("busyerr_sbcs", 7'h38, 32'h2044_0407);
    dmi_rd("busyerr_discard", 7'h3C, 32'h1111_1111);
    acc0 = acc_cnt;
    dmi_wr(7'h3C, 32'h3333_3333);
    repeat (10) @(negedge clk);
    check("busyerr_blocked", acc_cnt, acc0);
    dmi_wr(7'h38, 32'h0044_0000);
    dmi_rd("busyerr_w1c", 7'h38, 32'h2004_0407);
    rsp_delay = 1;
    expect_bus(1'b1, 32'h4000, 3'd2, 32'h4444_4444, 1'b0, 32'd0);
    dmi_wr(7'h3C, 32'h4444_4444);
    wait_idle("unblocked_idle");
    check("unblocked_req", acc_cnt, acc0 + 1);

    // alignment and size pre-checks
    acc0 = acc_cnt;
    dmi_wr(7'h39, 32'h0000_1002);
    dmi_wr(7'h3C, 32'h0000_0005);
    dmi_rd("misalign_sberror", 7'h38, 32'h2004_3407);
    dmi_wr(7'h38, 32'h0004_7000);
    dmi_wr(7'h38, 32'h0006_0000);
    dmi_wr(7'h39, 32'h0000_1000);
    dmi_wr(7'h3C, 32'h0000_0006);
    dmi_rd("size_sberror", 7'h38, 32'h2006_4407);
    dmi_wr(7'h38, 32'h0004_7000);
    dmi_rd("precheck_clear", 7'h38, 32'h2004_0407);
    check("precheck_no_req", acc_cnt, acc0);

    // timeout, then a late response that must be ignored
    dmi_wr(7'h38, 32'h0014_0000);
    rsp_delay = 12;
    expect_bus(1'b0, 32'h5000, 3'd2, 32'd0, 1'b0, 32'hCAFE_F00D);
    dmi_wr(7'h39, 32'h0000_5000);
    repeat (20) @(negedge clk);
    check("timeout_abort_cnt", abort_cnt, 1);
    check("timeout_abort_delay", abort_cyc - first_vld_cyc, 8);
    dmi_rd("timeout_sbcs", 7'h38, 32'h2014_1407);
    dmi_rd("timeout_sbdata_kept", 7'h3C, 32'h0000_0006);

    // dmactive clears state and aborts a pending request
    dmactive = 1'b0;
    @(negedge clk);
    dmactive = 1'b1;
    dmi_rd("dmactive_sbcs", 7'h38, 32'h2004_0407);
    dmi_rd("dmactive_addr", 7'h39, 32'd0);
    dmi_wr(7'h38, 32'h0014_0000);
    bus_req_ready = 1'b0;
    dmi_wr(7'h39, 32'h0000_6000);
    check("stall_req_valid", bus_req_valid, 1'b1);
    dmactive = 1'b0;
    @(posedge clk);
    #1;
    check("dmactive_drop_valid", bus_req_valid, 1'b0);
    dmactive = 1'b1;
    bus_req_ready = 1'b1;
    dmi_rd("dmactive_abort_sbcs", 7'h38, 32'h2004_0407);

    // error response: no autoincrement, no data update
    dmi_wr(7'h38, 32'h0015_0000);
    rsp_delay = 2;
    expect_bus(1'b0, 32'h7000, 3'd2, 32'd0, 1'b1, 32'h0000_0099);
    dmi_wr(7'h39, 32'h0000_7000);
    wait_idle("err_idle");
    dmi_rd("err_sbcs", 7'h38, 32'h2015_2407);
    dmi_rd("err_addr_kept", 7'h39, 32'h0000_7000);
    dmi_rd("err_data_kept", 7'h3C, 32'd0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
